oflow_mem_read_arbiter: RTL
===========================

# oflow_mem_read_arbiter

Round-robin arbiter sharing the single read port of the history-frame MEM buffer between up to NUM_REQ read sequencers, one per core. Each sequencer requests a frame burst and streams (frame, offset) line addresses. The arbiter grants one sequencer at a time and holds the grant for the whole burst. It forwards addresses to the buffer and tags returned data with the owner ID. The buffer writer has absolute priority: while it is busy, read issue stalls without losing the grant.

## Interface
Parameters:
- NUM_REQ, 4, number of read requesters (2..8)
- FRAME_W, 8, frame index width
- OFFSET_W, 8, line offset width
- ID_W, 2, requester ID width, $clog2(NUM_REQ)

Ports:
- clk  in  1  clock
- reset_N  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester line request, level, held while burst pending
- req_frame  in  NUM_REQ x FRAME_W  frame index of requested line
- req_offset  in  NUM_REQ x OFFSET_W  offset of requested line
- req_last  in  NUM_REQ  qualifies req: this line ends the burst
- wr_busy  in  1  buffer writer owns the memory this cycle
- gnt  out  NUM_REQ  one-hot grant, held for the burst
- line_ack  out  NUM_REQ  one-hot pulse, line accepted this cycle; requester advances its offset
- mem_re  out  1  read enable to buffer
- mem_frame  out  FRAME_W  registered frame index
- mem_offset  out  OFFSET_W  registered offset
- rd_valid  out  1  buffer data valid, one cycle after mem_re
- rd_id  out  ID_W  owner of data under rd_valid
- timeout_err  out  1  pulse, grant revoked by timeout (macro only, else tied 0)

## Operation
- States: IDLE, BURST.
- IDLE: if any req and !wr_busy, select the first requester with req high, searching from rr_ptr+1 modulo NUM_REQ. Register gnt and owner ID, then go to BURST. No read is issued in this cycle.
- BURST: issue = req[owner] && !wr_busy. On issue:
  - mem_re=1, mem_frame/mem_offset <= owner's inputs (registered).
  - line_ack[owner] pulses combinationally in the same cycle.
- Owner req low in BURST: bubble. No issue, grant held.
- wr_busy high: stall. mem_re=0, line_ack=0, state and grant held.
- Issue with req_last[owner]=1: rr_ptr <= owner, gnt cleared next cycle, return to IDLE. There is always at least one IDLE cycle between bursts.
- Non-owner req is ignored until the owner releases.
- rd_valid/rd_id: mem_re and owner ID delayed one cycle (buffer read latency 1).
- Only one requester pending: it is re-granted after a single IDLE cycle.

## Timing
- Reset values: state=IDLE, rr_ptr=NUM_REQ-1 (so requester 0 wins first), gnt=0, line_ack=0, mem_re=0, mem_frame=0, mem_offset=0, rd_valid=0, rd_id=0, timeout_err=0.
- Request to grant: req seen in cycle N (IDLE) gives gnt high in N+1, first line_ack at earliest N+1, mem_re high in N+2, rd_valid high in N+3.
- Throughput: one line per cycle within a burst while req stays high and wr_busy is low.
- Simultaneous wr_busy and req_last: the line is not accepted and the burst does not end.
- Reset mid-burst: everything returns to reset values asynchronously. An in-flight rd_valid is dropped.
- Requester rule: req_frame, req_offset and req_last must be stable while req is high until line_ack.

## Configuration
- OFLOW_RD_ARB_TIMEOUT_EN defined:
  - A 5-bit idle counter runs in BURST. It counts cycles with no issue and !wr_busy, and clears on issue.
  - On reaching 16, the grant is revoked, timeout_err pulses for 1 cycle, rr_ptr <= owner, and the state returns to IDLE.
- Not defined: no counter; a grant is held indefinitely until req_last; timeout_err tied 0.

## Test plan
- Single burst: req[1] high, 3 lines offsets 0,1,2, last on 2. Required response:
  - gnt=0010 one cycle after req.
  - mem_offset 0,1,2 on consecutive cycles.
  - rd_id=1 on three consecutive rd_valid cycles.
  - gnt=0 after the last line.
- Round robin: req[0], req[2] and req[3] high together, 2-line bursts each. Required response:
  - Grant order 0,2,3, each burst separated by exactly one IDLE cycle.
  - After the last burst, a new req[0]/req[3] pair is granted to 0.
- Writer priority: wr_busy high for 4 cycles mid-burst at offset 5. Required response:
  - mem_re=0 and no line_ack during those 4 cycles.
  - Offset 5 issued the cycle wr_busy drops.
  - gnt held throughout.
- Bubble and last collision: owner drops req for 2 cycles, then req_last coincides with wr_busy. Required response:
  - Grant held through the bubble.
  - Burst ends only once the last line issues with wr_busy low.
- Reset mid-burst: reset_N pulsed low during offset 3 of a burst. Required response:
  - All outputs take reset values immediately.
  - The next arbitration grants requester 0 first.
- Timeout (macro defined): owner holds grant with req low for 16 cycles. Required response:
  - timeout_err single pulse.
  - gnt cleared.
  - Next pending requester granted.
  - Without the macro, the grant is still held after 100 cycles.

Source files
------------

// File: rtl/oflow_mem_read_arbiter.sv
// Round-robin arbiter for the history-frame MEM buffer read port. The grant is held for a whole burst, and the writer always wins.
// Optional OFLOW_RD_ARB_TIMEOUT_EN revokes a grant whose owner sits idle for 16 cycles.

module oflow_mem_read_arbiter_lane (
  input  logic gnt,
  input  logic req,
  input  logic stall,
  output logic ack
);
  // gnt is only ever set while in BURST, so it alone qualifies the state
  assign ack = gnt & req & ~stall;
endmodule

module oflow_mem_read_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int FRAME_W  = 8,
  parameter int OFFSET_W = 8,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               reset_N,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0][FRAME_W-1:0]    req_frame,
  input  logic [NUM_REQ-1:0][OFFSET_W-1:0]   req_offset,
  input  logic [NUM_REQ-1:0]                 req_last,
  input  logic                               wr_busy,
  output logic [NUM_REQ-1:0]                 gnt,
  output logic [NUM_REQ-1:0]                 line_ack,
  output logic                               mem_re,
  output logic [FRAME_W-1:0]                 mem_frame,
  output logic [OFFSET_W-1:0]                mem_offset,
  output logic                               rd_valid,
  output logic [ID_W-1:0]                    rd_id,
  output logic                               timeout_err
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr, owner, re_id, sel_id;
  logic [NUM_REQ-1:0] sel_oh;
  logic               sel_found, issue;
  logic [1:0]         vld_pipe;   // [0] = mem_re, [1] = rd_valid

  always_comb begin
    sel_id    = '0;
    sel_oh    = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!sel_found && req[idx]) begin
        sel_found   = 1'b1;
        sel_id      = ID_W'(idx);
        sel_oh[idx] = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    oflow_mem_read_arbiter_lane u_lane (
      .gnt   (gnt[i]),
      .req   (req[i]),
      .stall (wr_busy),
      .ack   (line_ack[i])
    );
  end

  assign issue    = |line_ack;
  assign mem_re   = vld_pipe[0];
  assign rd_valid = vld_pipe[1];

`ifdef OFLOW_RD_ARB_TIMEOUT_EN
  logic [4:0] idle_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state      <= IDLE;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      owner      <= '0;
      gnt        <= '0;
      vld_pipe   <= '0;
      mem_frame  <= '0;
      mem_offset <= '0;
      re_id      <= '0;
      rd_id      <= '0;
`ifdef OFLOW_RD_ARB_TIMEOUT_EN
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      vld_pipe <= {vld_pipe[0], issue};
      rd_id    <= re_id;
      if (issue) begin
        mem_frame  <= req_frame[owner];
        mem_offset <= req_offset[owner];
        re_id      <= owner;
      end
`ifdef OFLOW_RD_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (sel_found && !wr_busy) begin
            gnt   <= sel_oh;
            owner <= sel_id;
            state <= BURST;
`ifdef OFLOW_RD_ARB_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
        end
        BURST: begin
          if (issue && req_last[owner]) begin
            gnt    <= '0;
            rr_ptr <= owner;
            state  <= IDLE;
          end
`ifdef OFLOW_RD_ARB_TIMEOUT_EN
          if (issue) begin
            idle_cnt <= '0;
          end else if (!wr_busy) begin
            if (idle_cnt == 5'd15) begin
              // 16th idle cycle: revoke and hand the pointer past the stalled owner
              gnt         <= '0;
              rr_ptr      <= owner;
              state       <= IDLE;
              timeout_err <= 1'b1;
              idle_cnt    <= '0;
            end else begin
              idle_cnt <= idle_cnt + 5'd1;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
